// File: rtl/host_uart_pkg.sv
// Shared types and constants for the host board UART transmit controller.
package host_uart_pkg;

  localparam int unsigned HOST_CLK_HZ          = 5_000_000;
  localparam int unsigned HOST_BAUD            = 115_200;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = HOST_CLK_HZ / HOST_BAUD;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/host_uart_sched_arb.sv
// Two-way round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module host_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last_b;

  // On a tie the requester not served last time wins.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      grant[0] = req[0] & (~req[1] | last_b);
      grant[1] = req[1] & (~req[0] | ~last_b);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_b <= 1'b1;
    end else if (|grant) begin
      last_b <= grant[1];
    end
  end

endmodule

// File: rtl/host_uart_sched.sv
// Arbitrates two byte requesters and serializes the granted byte as 8N1
// (8E1 when HOST_UART_PARITY_EN is defined) onto uart_tx.
module host_uart_sched
  import host_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic [7:0] a_data,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [7:0] b_data,
  output logic       b_ack,
  output logic       busy,
  output logic       uart_tx
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_t       state, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              tx_d, a_ack_d, b_ack_d, busy_d;
  logic              baud_done;
  logic [1:0]        grant;

  host_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({b_req, a_req}),
    .enable (state == IDLE),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      uart_tx <= 1'b1;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      uart_tx <= tx_d;
      a_ack   <= a_ack_d;
      b_ack   <= b_ack_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state;
    baud_d    = baud_q;
    bit_d     = bit_q;
    data_d    = data_q;
    tx_d      = uart_tx;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    busy_d    = busy;
    baud_done = (baud_q == '0);

    // Every non-idle state spends one baud period; the counter stops at 0.
    if (state != IDLE && !baud_done) begin
      baud_d = baud_q - BAUD_W'(1);
    end

    case (state)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (|grant) begin
          data_d  = grant[0] ? a_data : b_data;
          a_ack_d = grant[0];
          b_ack_d = grant[1];
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
          tx_d    = data_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = BAUD_LOAD;
          if (bit_q == 3'd7) begin
`ifdef HOST_UART_PARITY_EN
            tx_d    = ^data_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end
      end
`ifdef HOST_UART_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_d  = BAUD_LOAD;
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          busy_d  = 1'b0;
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_host_uart_sched.sv
// Self-checking bench for host_uart_sched at CLKS_PER_BIT=4; honours
// HOST_UART_PARITY_EN for the expected frame format.
module tb_host_uart_sched;

  localparam int unsigned C = 4;
`ifdef HOST_UART_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = NBITS * C;
  localparam int TMO = 3 * FRAME;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_ack, b_ack, busy, uart_tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_last_b;
  logic [7:0] exp_q[$];

  bit   mon_active = 1'b0;
  int   mon_cnt = 0;
  logic samp [FRAME];

  typedef struct {
    bit         ra;
    bit         rb;
    logic [7:0] da;
    logic [7:0] db;
    bit         first_b;
  } vec_t;
  vec_t vecs[7];

  host_uart_sched #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_req   (a_req),
    .a_data  (a_data),
    .a_ack   (a_ack),
    .b_req   (b_req),
    .b_data  (b_data),
    .b_ack   (b_ack),
    .busy    (busy),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode a captured frame: every bit constant for C cycles, framing, byte.
  task automatic decode_frame();
    logic [NBITS-1:0] bits;
    logic [7:0]       d;
    bit               stable;
    stable = 1'b1;
    for (int b = 0; b < NBITS; b++) begin
      bits[b] = samp[b*C];
      for (int s = 1; s < C; s++)
        if (samp[b*C+s] !== bits[b]) stable = 1'b0;
    end
    d = bits[8:1];
    chk("bit_stable", 32'(stable), 32'd1);
    chk("start_bit", 32'(bits[0]), 32'd0);
    chk("stop_bit", 32'(bits[NBITS-1]), 32'd1);
`ifdef HOST_UART_PARITY_EN
    chk("parity_bit", 32'(bits[9]), 32'(^d));
`endif
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got %0h expected no frame", d);
    end else begin
      chk("rx_byte", 32'(d), 32'(exp_q.pop_front()));
    end
  endtask

  // Line monitor: captures FRAME samples from the first low cycle.
  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx == 1'b0) begin
        mon_active = 1'b1;
        samp[0] = 1'b0;
        mon_cnt = 1;
      end
    end else begin
      samp[mon_cnt] = uart_tx;
      mon_cnt++;
      if (mon_cnt == FRAME) begin
        mon_active = 1'b0;
        decode_frame();
      end
    end
  end

  task automatic wait_ack(output bit got_a, output bit got_b, output int at);
    got_a = 1'b0;
    got_b = 1'b0;
    at = -1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        got_a = a_ack;
        got_b = b_ack;
        at = cyc;
        return;
      end
    end
  endtask

  // Wait for the model-predicted grant, queue its byte, check the pulse width.
  task automatic expect_grant(input string name, input bit exp_b, input logic [7:0] byte_v,
                              input bit drop, output int at);
    bit ga, gb;
    wait_ack(ga, gb, at);
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack expected ack within %0d cycles", name, TMO);
      return;
    end
    chk({name, "_ack"}, {30'd0, gb, ga}, exp_b ? 32'd2 : 32'd1);
    exp_q.push_back(byte_v);
    if (drop) begin
      if (ga) a_req = 1'b0;
      if (gb) b_req = 1'b0;
    end
    @(negedge clk);
    chk({name, "_ackw"}, {30'd0, b_ack, a_ack}, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || mon_active) && n < TMO);
    if (n >= TMO) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_req = 1'b0;
    b_req = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  t0, t1, t2;
    int  ts[4];
    int  n;
    bit  ga, gb, first_b, ra, rb;
    logic [7:0] da, db, bv;
    logic [7:0] busy_bytes[2];

    vecs[0] = '{1'b1, 1'b1, 8'h41, 8'h42, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h55, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'h0F, 8'hF0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h80, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h01, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 8'hAA, 8'h5A, 1'b0};
    busy_bytes[0] = 8'h55;
    busy_bytes[1] = 8'h07;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Arbitration table from reset
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a_req = vecs[i].ra; a_data = vecs[i].da;
      b_req = vecs[i].rb; b_data = vecs[i].db;
      t0 = cyc;
      expect_grant($sformatf("vec%0d", i), vecs[i].first_b,
                   vecs[i].first_b ? vecs[i].db : vecs[i].da, 1'b1, t1);
      chk($sformatf("vec%0d_latency", i), 32'(t1 - t0), 32'd1);
      if (vecs[i].ra && vecs[i].rb) begin
        expect_grant($sformatf("vec%0d_2nd", i), !vecs[i].first_b,
                     vecs[i].first_b ? vecs[i].da : vecs[i].db, 1'b1, t2);
        chk($sformatf("vec%0d_gap", i), 32'(t2 - t1), 32'(FRAME + 1));
      end
      wait_idle();
    end

    // Busy duration equals the frame length
    for (int i = 0; i < 2; i++) begin
      do_reset();
      @(negedge clk);
      a_req = 1'b1; a_data = busy_bytes[i];
      wait_ack(ga, gb, t0);
      chk("busy_ack", {30'd0, gb, ga}, 32'd1);
      exp_q.push_back(busy_bytes[i]);
      a_req = 1'b0;
      n = 0;
      while (busy && n < TMO) begin
        n++;
        @(negedge clk);
      end
      chk($sformatf("busy_len_%0h", busy_bytes[i]), 32'(n), 32'(FRAME));
      wait_idle();
    end

    // Both held continuously: alternating grants, FRAME+1 period
    do_reset();
    @(negedge clk);
    a_data = 8'h11; b_data = 8'h22; a_req = 1'b1; b_req = 1'b1;
    expect_grant("cont0", 1'b0, 8'h11, 1'b0, ts[0]); a_data = 8'h33;
    expect_grant("cont1", 1'b1, 8'h22, 1'b0, ts[1]); b_data = 8'h44;
    expect_grant("cont2", 1'b0, 8'h33, 1'b0, ts[2]);
    expect_grant("cont3", 1'b1, 8'h44, 1'b0, ts[3]);
    a_req = 1'b0; b_req = 1'b0;
    for (int i = 1; i < 4; i++)
      chk($sformatf("cont_period%0d", i), 32'(ts[i] - ts[i-1]), 32'(FRAME + 1));
    wait_idle();

    // Data changed the cycle after ack has no effect
    @(negedge clk);
    a_req = 1'b1; a_data = 8'h12;
    wait_ack(ga, gb, t0);
    chk("chg_ack", {30'd0, gb, ga}, 32'd1);
    exp_q.push_back(8'h12);
    a_req = 1'b0;
    @(negedge clk);
    a_data = 8'hFF;
    wait_idle();

    // Reset during data bit 3 of 0xF0, then re-grant of the pending request
    do_reset();
    @(negedge clk);
    a_req = 1'b1; a_data = 8'hF0;
    wait_ack(ga, gb, t0);
    chk("mid_ack", {30'd0, gb, ga}, 32'd1);
    repeat (4 * C + 1) @(negedge clk);
    chk("mid_bit3", 32'(uart_tx), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(uart_tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", {30'd0, b_ack, a_ack}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_grant("mid_regrant", 1'b0, 8'hF0, 1'b1, t1);
    wait_idle();

    // Randomized traffic against the round-robin model
    do_reset();
    model_last_b = 1'b1;
    for (int it = 0; it < 16; it++) begin
      n = int'($urandom_range(0, 2));
      ra = (n != 1);
      rb = (n != 0);
      da = 8'($urandom);
      db = 8'($urandom);
      @(negedge clk);
      a_req = ra; a_data = da; b_req = rb; b_data = db;
      first_b = (ra && rb) ? !model_last_b : rb;
      bv = first_b ? db : da;
      expect_grant($sformatf("rnd%0d", it), first_b, bv, 1'b1, t1);
      model_last_b = first_b;
      if ($urandom_range(0, 1) == 1) begin
        if (first_b) b_data = 8'($urandom);
        else a_data = 8'($urandom);
      end
      if (ra && rb) begin
        bv = first_b ? da : db;
        expect_grant($sformatf("rnd%0d_2nd", it), !first_b, bv, 1'b1, t2);
        model_last_b = !first_b;
        chk($sformatf("rnd%0d_gap", it), 32'(t2 - t1), 32'(FRAME + 1));
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    @(negedge clk);
    chk("pending_frames", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
